// File: rtl/dlx_mem_arbiter.sv
// Arbitrates one single-ported unified memory between DLX fetch (read-only) and data ports.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is data-over-fetch priority.
//
// state   | meaning
// IDLE    | sample requests, latch winner onto m_*
// SERVE_I | fetch access in flight on memory
// SERVE_D | data access in flight on memory
// RESP    | one-cycle ready pulse to the served side
module dlx_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_enable,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_enable,
   input  logic              d_readnotwrite,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_enable,
   output logic              m_readnotwrite,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // The cycle after this count is the TIMEOUT-th cycle of m_enable
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              pick_d;
   logic              serve_done;
   logic [DATA_W-1:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_d_next;

   always_comb begin
      pick_d = d_enable && (!i_enable || rr_d_next);
   end
`else
   always_comb begin
      pick_d = d_enable;
   end
`endif

   always_comb begin
      serve_done = m_ready || (wait_cnt == CNT_LAST);
      resp_data  = m_ready ? m_rdata : '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         wait_cnt       <= '0;
         m_enable       <= 1'b0;
         m_address      <= '0;
         m_readnotwrite <= 1'b1;
         m_wdata        <= '0;
         i_ready        <= 1'b0;
         d_ready        <= 1'b0;
         i_data         <= '0;
         d_rdata        <= '0;
         timeout_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_d_next      <= 1'b1;
`endif
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (i_enable || d_enable) begin
                  wait_cnt <= '0;
                  m_enable <= 1'b1;
                  if (pick_d) begin
                     m_address      <= d_address;
                     m_readnotwrite <= d_readnotwrite;
                     m_wdata        <= d_wdata;
                     state          <= SERVE_D;
                  end else begin
                     m_address      <= i_address;
                     m_readnotwrite <= 1'b1;
                     state          <= SERVE_I;
                  end
`ifdef ARB_ROUND_ROBIN_EN
                  if (i_enable && d_enable) begin
                     rr_d_next <= !pick_d;
                  end
`endif
               end
            end
            SERVE_I, SERVE_D: begin
               if (serve_done) begin
                  m_enable <= 1'b0;
                  state    <= RESP;
                  if (!m_ready) begin
                     timeout_err <= 1'b1;
                  end
                  if (state == SERVE_I) begin
                     i_ready <= 1'b1;
                     i_data  <= resp_data;
                  end else begin
                     d_ready <= 1'b1;
                     // stores leave the previous load data on d_rdata
                     if (m_readnotwrite) begin
                        d_rdata <= resp_data;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter with a delay-programmable memory model and response scoreboard.
module tb_dlx_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic          i_enable = 1'b0;
   logic          i_ready;
   logic [DW-1:0] i_data;
   logic [AW-1:0] d_address = '0;
   logic          d_enable = 1'b0;
   logic          d_readnotwrite = 1'b1;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] m_address;
   logic          m_enable;
   logic          m_readnotwrite;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ready;
   logic          timeout_err;

   dlx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_address(i_address), .i_enable(i_enable), .i_ready(i_ready), .i_data(i_data),
      .d_address(d_address), .d_enable(d_enable), .d_readnotwrite(d_readnotwrite),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
      .m_address(m_address), .m_enable(m_enable), .m_readnotwrite(m_readnotwrite),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // memory model: m_ready after mem_delay cycles of m_enable, never when mem_hang
   logic [DW-1:0] mem [0:63];
   int            mem_delay = 0;
   bit            mem_hang = 1'b0;
   int            mem_wait = 0;
   logic [AW-1:0] last_addr = '0;
   logic          last_rnw = 1'b1;
   logic [DW-1:0] last_wdata = '0;

   assign m_ready = m_enable && !mem_hang && (mem_wait == mem_delay);
   assign m_rdata = mem[m_address[7:2]];

   always @(posedge clk) begin
      mem_wait <= m_enable ? mem_wait + 1 : 0;
      if (m_enable && m_ready) begin
         last_addr  <= m_address;
         last_rnw   <= m_readnotwrite;
         last_wdata <= m_wdata;
         if (!m_readnotwrite) mem[m_address[7:2]] = m_wdata;
      end
   end

   typedef struct packed {
      logic          is_d;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_d_rdata = '0;
   int            cyc, en_cnt;
   bit            to;

   task automatic wait_ready(output int n_cyc, output int n_en, output bit expired);
      n_cyc = 0; n_en = 0; expired = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         n_cyc++;
         if (m_enable) n_en++;
         if (i_ready || d_ready) begin
            expired = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL rst_m_enable: got %b exp 0", m_enable); end
      checks++; if ({i_ready, d_ready, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {i_ready, d_ready, timeout_err}); end
      checks++; if (m_readnotwrite !== 1'b1) begin errors++; $display("FAIL rst_m_rnw: got %b exp 1", m_readnotwrite); end
      checks++; if ({m_address, m_wdata, i_data, d_rdata} !== '0) begin errors++; $display("FAIL rst_regs: got %h %h %h %h exp 0", m_address, m_wdata, i_data, d_rdata); end
      rst = 1'b0;
      exp_d_rdata = '0;
      sb.delete();
   endtask

   task automatic test_single_fetch;
      @(posedge clk); #1;
      mem[4] = 32'hDEAD_BEEF; mem_delay = 0; mem_hang = 1'b0;
      i_address = 32'h10; i_enable = 1'b1;
      sb.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF});
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0;
      checks++; if (to || cyc != 2) begin errors++; $display("FAIL fetch_latency: got %0d cycles (expired=%0d) exp 2", cyc, to); end
      checks++; if (en_cnt != 1) begin errors++; $display("FAIL fetch_m_enable_cycles: got %0d exp 1", en_cnt); end
      e = sb.pop_front();
      checks++; if ({d_ready, i_ready} !== {e.is_d, !e.is_d} || i_data !== e.data) begin errors++; $display("FAIL fetch_resp: got d=%b i=%b data=%h exp data=%h", d_ready, i_ready, i_data, e.data); end
      checks++; if (last_addr !== 32'h10 || last_rnw !== 1'b1) begin errors++; $display("FAIL fetch_m_bus: got addr=%h rnw=%b exp 10 1", last_addr, last_rnw); end
      @(posedge clk); #1;
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b exp 0", i_ready); end
   endtask

   task automatic test_store_load;
      @(posedge clk); #1;
      mem_delay = 2;
      d_address = 32'h40; d_wdata = 32'h1234_5678; d_readnotwrite = 1'b0; d_enable = 1'b1;
      sb.push_back('{is_d: 1'b1, data: exp_d_rdata});
      wait_ready(cyc, en_cnt, to);
      d_enable = 1'b0;
      checks++; if (to || cyc != 4) begin errors++; $display("FAIL store_latency: got %0d cycles exp 4", cyc); end
      checks++; if (last_rnw !== 1'b0 || last_wdata !== 32'h1234_5678 || last_addr !== 32'h40) begin errors++; $display("FAIL store_m_bus: got rnw=%b wdata=%h addr=%h exp 0 12345678 40", last_rnw, last_wdata, last_addr); end
      e = sb.pop_front();
      checks++; if ({d_ready, i_ready} !== {e.is_d, !e.is_d} || d_rdata !== e.data) begin errors++; $display("FAIL store_resp: got d=%b i=%b rdata=%h exp rdata=%h", d_ready, i_ready, d_rdata, e.data); end
      @(posedge clk); #1;
      mem_delay = 1;
      d_readnotwrite = 1'b1; d_enable = 1'b1;
      exp_d_rdata = 32'h1234_5678;
      sb.push_back('{is_d: 1'b1, data: exp_d_rdata});
      wait_ready(cyc, en_cnt, to);
      d_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || {d_ready, i_ready} !== {e.is_d, !e.is_d} || d_rdata !== e.data) begin errors++; $display("FAIL load_resp: got d=%b rdata=%h exp rdata=%h", d_ready, d_rdata, e.data); end
   endtask

   task automatic test_conflict;
      bit expect_d;
      mem[8] = 32'hA5A5_0001; mem[9] = 32'h5A5A_0002;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         mem_delay = 0;
         i_address = 32'h20; d_address = 32'h24; d_readnotwrite = 1'b1;
         i_enable = 1'b1; d_enable = 1'b1;
         expect_d = (r == 0) ? 1'b1 : !RR;
         sb.push_back('{is_d: expect_d, data: expect_d ? 32'h5A5A_0002 : 32'hA5A5_0001});
         if (expect_d) exp_d_rdata = 32'h5A5A_0002;
         wait_ready(cyc, en_cnt, to);
         i_enable = 1'b0; d_enable = 1'b0;
         e = sb.pop_front();
         checks++; if (to || {d_ready, i_ready} !== {e.is_d, !e.is_d} || (e.is_d ? d_rdata : i_data) !== e.data) begin
            errors++; $display("FAIL conflict_%0d: got d=%b i=%b data=%h exp d=%b data=%h", r, d_ready, i_ready, e.is_d ? d_rdata : i_data, e.is_d, e.data);
         end
      end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      mem_delay = 0;
      i_address = 32'h20; d_address = 32'h24; d_readnotwrite = 1'b1;
      i_enable = 1'b1; d_enable = 1'b1;
      sb.push_back('{is_d: 1'b1, data: 32'h5A5A_0002});
      sb.push_back('{is_d: 1'b0, data: 32'hA5A5_0001});
      wait_ready(cyc, en_cnt, to);
      d_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || d_ready !== e.is_d || d_rdata !== e.data) begin errors++; $display("FAIL b2b_first: got d=%b rdata=%h exp d=%b rdata=%h", d_ready, d_rdata, e.is_d, e.data); end
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || cyc != 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles exp 3", cyc); end
      checks++; if (i_ready !== !e.is_d || i_data !== e.data) begin errors++; $display("FAIL b2b_second: got i=%b data=%h exp data=%h", i_ready, i_data, e.data); end
   endtask

   task automatic test_timeout;
      @(posedge clk); #1;
      mem_hang = 1'b1;
      i_address = 32'h30; i_enable = 1'b1;
      sb.push_back('{is_d: 1'b0, data: 32'hFFFF_FFFF});
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0; mem_hang = 1'b0;
      checks++; if (to || en_cnt != TO || cyc != TO + 1) begin errors++; $display("FAIL timeout_window: got en=%0d cyc=%0d exp en=%0d cyc=%0d", en_cnt, cyc, TO, TO + 1); end
      e = sb.pop_front();
      checks++; if (i_ready !== 1'b1 || i_data !== e.data || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_resp: got i=%b data=%h err=%b exp 1 %h 1", i_ready, i_data, timeout_err, e.data); end
      @(posedge clk); #1;
      mem_delay = 0;
      i_address = 32'h10; i_enable = 1'b1;
      sb.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF});
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || i_data !== e.data || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got data=%h err=%b exp %h 1", i_data, timeout_err, e.data); end
   endtask

   task automatic test_rst_mid;
      int pulses;
      @(posedge clk); #1;
      mem_delay = 4;
      i_address = 32'h10; i_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; i_enable = 1'b0;
      checks++; if ({m_enable, i_ready, d_ready, timeout_err} !== 4'b0000) begin errors++; $display("FAIL rst_mid_state: got en/ir/dr/err=%b exp 0000", {m_enable, i_ready, d_ready, timeout_err}); end
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (i_ready || d_ready) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_dropped: got %0d ready pulses exp 0", pulses); end
      mem_delay = 1;
      i_address = 32'h20; i_enable = 1'b1;
      sb.push_back('{is_d: 1'b0, data: 32'hA5A5_0001});
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || cyc != 3 || i_data !== e.data) begin errors++; $display("FAIL rst_mid_recover: got cyc=%0d data=%h exp 3 %h", cyc, i_data, e.data); end
   endtask

   task automatic test_timeout_edge;
      @(posedge clk); #1;
      mem_delay = TO - 1;
      i_address = 32'h10; i_enable = 1'b1;
      sb.push_back('{is_d: 1'b0, data: 32'hDEAD_BEEF});
      wait_ready(cyc, en_cnt, to);
      i_enable = 1'b0;
      e = sb.pop_front();
      checks++; if (to || en_cnt != TO || i_data !== e.data || timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_edge: got en=%0d data=%h err=%b exp %0d %h 0", en_cnt, i_data, timeout_err, TO, e.data); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      test_reset;
      test_single_fetch;
      test_store_load;
      test_conflict;
      test_back_to_back;
      test_timeout;
      test_rst_mid;
      test_timeout_edge;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
